seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, handshaked successor to the team's 4-bit combinational ALU tile. Operand width is set by WIDTH, and results are 2*WIDTH bits wide, so a 4-bit build fills an 8-bit output bus. The block adds iterative multiply/divide, an accumulator operand mode and status flags. It sits between the tile's input pins and output bus, with valid/ready on both sides.

Parameters:
WIDTH, 4, operand width in bits (>=2, power of two)
DIV_EN, 1, 1 = divider present; 0 = opcode 9 treated as reserved

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand/opcode valid
in_ready  out  1  block can accept an operation
op  in  4  opcode
a  in  WIDTH  operand A
b  in  WIDTH  operand B
use_acc  in  1  1 = use accumulator in place of a
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  2*WIDTH  result
flags  out  4  {err, ovf, carry, zero}
busy  out  1  multi-cycle op in progress

Behaviour:
- Reset: state IDLE; in_ready=1, out_valid=0, busy=0, result=0, flags=0, acc=0, all datapath registers 0.
- States: IDLE -> (accept, single-cycle op) -> DONE; IDLE -> (accept, MUL/DIV with b!=0) -> BUSY; BUSY -> (WIDTH iterations complete) -> DONE; DONE -> (out_ready) -> IDLE.
- in_ready = (state==IDLE). Accept = in_valid & in_ready. Inputs are captured at accept; later changes to a, b or op are ignored.
- Effective A = use_acc ? acc : a.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL, 7 SHR, 8 MUL, 9 DIV, A CMP, B PASS B. C-F reserved.
- Arithmetic:
  - Unsigned operands; result zero-extended to 2*WIDTH.
  - ADD: result[WIDTH:0] = A+B; carry = bit WIDTH.
  - SUB: low WIDTH bits = A-B mod 2^WIDTH; carry = borrow (A<B).
  - ovf: signed two's-complement overflow of the low WIDTH bits for ADD/SUB only; 0 for all other ops.
  - SHL/SHR: logical shift of A by b[log2(WIDTH)-1:0]; low WIDTH bits only.
  - CMP: result = (A<B) ? 1 : 0; carry = (A==B).
  - MUL: unsigned shift-add, one partial product per cycle; full 2*WIDTH-bit product.
  - DIV: restoring, one quotient bit per cycle; result = {remainder, quotient}.
- Latency (accept edge to out_valid high): single-cycle ops 1 cycle; MUL/DIV WIDTH+1 cycles. busy=1 only in BUSY.
- Division by zero: no iteration; DONE after 1 cycle; quotient = all ones, remainder = A, err=1.
- Reserved opcodes, and opcode 9 when DIV_EN=0: DONE after 1 cycle; result=0; err=1; zero=1.
- zero flag = (result == 0) across all 2*WIDTH bits.
- DONE hold: result and flags stay stable while out_valid=1 and out_ready=0, for any number of cycles.
- Accumulator: on output handshake (out_valid & out_ready), acc <= result[WIDTH-1:0], unless err=1, in which case acc is unchanged.
- rst mid-operation (BUSY or DONE): aborts on the next edge; the pending result is discarded and all reset values apply.
- in_valid asserted while in_ready=0 has no effect; there is no queueing.

Test Plan:
- WIDTH=4. ADD a=9, b=8, out_ready=1 -> out_valid one cycle after accept; result=8'h11, carry=1, ovf=1 (-7 + -8 overflows), zero=0; in_ready high again on the following cycle.
- SUB a=3, b=5 -> result=8'h0E, carry=1, ovf=0. SUB a=5, b=5 -> result=0, zero=1.
- MUL a=15, b=15 -> busy high for 4 cycles, out_valid at accept+5, result=8'hE1. Hold out_ready=0 for 3 cycles -> result stable and in_ready=0 throughout.
- DIV a=13, b=4 -> result=8'h13 (remainder 1, quotient 3) at accept+5. DIV a=7, b=0 -> result=8'h7F, err=1 at accept+1.
- Accumulator chain: ADD a=6, b=1, then ADD use_acc=1, b=2 -> second result=9; a then SHL use_acc=1, b=1 -> result=8'h02 (18 mod 16). Reserved op 4'hD afterwards -> err=1 and acc unchanged at 2.
- Reset mid-op: start MUL 15x15, assert rst for one cycle at accept+2 -> next cycle out_valid=0, busy=0, in_ready=1, acc=0; a new ADD 1+1 then returns result=2.

Source files
------------

// File: rtl/seq_alu.sv
// Handshaked ALU with iterative shift-add multiply, restoring divide, an
// accumulator operand mode and {err, ovf, carry, zero} status flags.
module seq_alu #(
   parameter int WIDTH  = 4,
   parameter bit DIV_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 use_acc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic [3:0]           flags,
   output logic                 busy
);

   localparam int SW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD   = 4'h0,
      OP_SUB   = 4'h1,
      OP_AND   = 4'h2,
      OP_OR    = 4'h3,
      OP_XOR   = 4'h4,
      OP_NOT   = 4'h5,
      OP_SHL   = 4'h6,
      OP_SHR   = 4'h7,
      OP_MUL   = 4'h8,
      OP_DIV   = 4'h9,
      OP_CMP   = 4'hA,
      OP_PASSB = 4'hB
   } op_t;

   state_t              state, state_nxt;
   logic [WIDTH-1:0]    acc;
   logic [WIDTH-1:0]    hi, lo;       // product / {remainder, quotient} pair
   logic [WIDTH-1:0]    opnd;         // multiplicand or divisor
   logic                is_div;
   logic [SW-1:0]       cnt;

   logic [WIDTH-1:0]    eff_a;
   logic [SW-1:0]       shamt;
   logic [WIDTH:0]      sum_ext, dif_ext;
   logic [2*WIDTH-1:0]  alu_res;
   logic                alu_err, alu_ovf, alu_carry;
   logic                start_mul, start_div, start_iter;

   logic [WIDTH:0]      mul_sum;
   logic [WIDTH:0]      div_trial;
   logic [WIDTH-1:0]    div_rem;
   logic                div_ge;
   logic [WIDTH-1:0]    hi_nxt, lo_nxt;

   assign eff_a      = use_acc ? acc : a;
   assign shamt      = b[SW-1:0];
   assign sum_ext    = {1'b0, eff_a} + {1'b0, b};
   assign dif_ext    = {1'b0, eff_a} - {1'b0, b};
   assign start_iter = start_mul | start_div;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      alu_res   = '0;
      alu_err   = 1'b0;
      alu_ovf   = 1'b0;
      alu_carry = 1'b0;
      start_mul = 1'b0;
      start_div = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res[WIDTH:0] = sum_ext;
            alu_carry        = sum_ext[WIDTH];
            alu_ovf          = (eff_a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != eff_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res[WIDTH-1:0] = dif_ext[WIDTH-1:0];
            alu_carry          = dif_ext[WIDTH];
            alu_ovf            = (eff_a[WIDTH-1] != b[WIDTH-1]) && (dif_ext[WIDTH-1] != eff_a[WIDTH-1]);
         end
         OP_AND:   alu_res[WIDTH-1:0] = eff_a & b;
         OP_OR:    alu_res[WIDTH-1:0] = eff_a | b;
         OP_XOR:   alu_res[WIDTH-1:0] = eff_a ^ b;
         OP_NOT:   alu_res[WIDTH-1:0] = ~eff_a;
         OP_SHL:   alu_res[WIDTH-1:0] = eff_a << shamt;
         OP_SHR:   alu_res[WIDTH-1:0] = eff_a >> shamt;
         OP_MUL:   start_mul = (b != '0);
         OP_DIV: begin
            if (!DIV_EN) begin
               alu_err = 1'b1;
            end else if (b == '0) begin
               alu_res = {eff_a, {WIDTH{1'b1}}};
               alu_err = 1'b1;
            end else begin
               start_div = 1'b1;
            end
         end
         OP_CMP: begin
            alu_res[0] = (eff_a < b);
            alu_carry  = (eff_a == b);
         end
         OP_PASSB: alu_res[WIDTH-1:0] = b;
         default:  alu_err = 1'b1;
      endcase
   end

   // One iteration step: shift-add for multiply, restore-or-subtract for divide.
   assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
   assign div_trial = {hi, lo[WIDTH-1]};
   assign div_ge    = (div_trial >= {1'b0, opnd});
   assign div_rem   = div_trial[WIDTH-1:0] - opnd;

   always_comb begin
      if (is_div) begin
         hi_nxt = div_ge ? div_rem : div_trial[WIDTH-1:0];
         lo_nxt = {lo[WIDTH-2:0], div_ge};
      end else begin
         {hi_nxt, lo_nxt} = {mul_sum, lo[WIDTH-1:1]};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = start_iter ? S_BUSY : S_DONE;
         end
         S_BUSY: begin
            busy = 1'b1;
            if (cnt == '0) state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         hi     <= '0;
         lo     <= '0;
         opnd   <= '0;
         is_div <= 1'b0;
         cnt    <= '0;
         result <= '0;
         flags  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  if (start_iter) begin
                     is_div <= start_div;
                     opnd   <= start_div ? b : eff_a;
                     hi     <= '0;
                     lo     <= start_div ? eff_a : b;
                     cnt    <= SW'(WIDTH - 1);
                  end else begin
                     result <= alu_res;
                     flags  <= {alu_err, alu_ovf, alu_carry, (alu_res == '0)};
                  end
               end
            end
            S_BUSY: begin
               hi  <= hi_nxt;
               lo  <= lo_nxt;
               cnt <= cnt - SW'(1);
               if (cnt == '0) begin
                  result <= {hi_nxt, lo_nxt};
                  flags  <= {3'b000, ({hi_nxt, lo_nxt} == '0)};
               end
            end
            S_DONE: begin
               // Error results never reach the accumulator.
               if (out_valid && out_ready && !flags[3]) acc <= result[WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=4): directed vector table, hand-written
// hold/reset sequences, and randomized operations against an arithmetic model.
module tb_seq_alu;

   localparam int W = 4;
   localparam int M = 1 << W;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      op;
   logic [W-1:0]    a, b;
   logic            use_acc;
   logic            out_valid;
   logic            out_ready;
   logic [2*W-1:0]  result;
   logic [3:0]      flags;
   logic            busy;

   int n_cmp = 0;
   int n_bad = 0;
   logic [W-1:0] model_acc;

   seq_alu #(.WIDTH(W), .DIV_EN(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .use_acc   (use_acc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]     op;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic           ua;
      int             hold;
      logic [2*W-1:0] res;
      logic [3:0]     fl;
      int             lat;
   } vec_t;

   vec_t tbl [25];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the unsigned operands.
   function automatic void model(input logic [3:0] opc, input int x, input int y,
                                 output logic [2*W-1:0] res, output logic [3:0] fl,
                                 output int lat);
      int r, sx, sy, s;
      logic err, ovf, carry;
      r = 0; err = 0; ovf = 0; carry = 0; lat = 1;
      sx = (x >= M/2) ? x - M : x;
      sy = (y >= M/2) ? y - M : y;
      case (opc)
         4'h0: begin r = x + y; carry = (r >= M); s = sx + sy; ovf = (s < -M/2) || (s >= M/2); end
         4'h1: begin r = (x - y + M) % M; carry = (x < y); s = sx - sy; ovf = (s < -M/2) || (s >= M/2); end
         4'h2: r = x & y;
         4'h3: r = x | y;
         4'h4: r = x ^ y;
         4'h5: r = (M - 1) - x;
         4'h6: r = (x << (y % W)) % M;
         4'h7: r = x >> (y % W);
         4'h8: begin r = x * y; if (y != 0) lat = W + 1; end
         4'h9: begin
            if (y == 0) begin r = x * M + (M - 1); err = 1; end
            else begin r = (x % y) * M + (x / y); lat = W + 1; end
         end
         4'hA: begin r = (x < y) ? 1 : 0; carry = (x == y); end
         4'hB: r = y;
         default: err = 1;
      endcase
      res = r[2*W-1:0];
      fl  = {err, ovf, carry, (r == 0)};
   endfunction

   task automatic do_op(input string name, input logic [3:0] op_i, input logic [W-1:0] a_i,
                        input logic [W-1:0] b_i, input logic ua, input int hold,
                        input logic [2*W-1:0] exp_res, input logic [3:0] exp_fl, input int exp_lat);
      int lat, busy_n, guard;
      guard = 0;
      while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
      check({name, " in_ready"}, in_ready, 1);
      in_valid = 1; op = op_i; a = a_i; b = b_i; use_acc = ua; out_ready = 0;
      @(posedge clk); #1;
      // Scramble inputs after accept; in_valid pulses while busy must be ignored.
      op = 4'($urandom); a = W'($urandom); b = W'($urandom); use_acc = 1'($urandom);
      in_valid = 1'($urandom);
      lat = 1; busy_n = 0;
      while (!out_valid && lat < 50) begin
         if (busy) busy_n++;
         @(posedge clk); #1;
         in_valid = 1'($urandom);
         lat++;
      end
      check({name, " latency"}, lat, exp_lat);
      check({name, " busy"}, busy_n, exp_lat - 1);
      check({name, " result"}, result, exp_res);
      check({name, " flags"}, flags, exp_fl);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         in_valid = 1'($urandom);
         check({name, " hold"}, {out_valid, in_ready, result, flags}, {1'b1, 1'b0, exp_res, exp_fl});
      end
      in_valid = 0; out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      check({name, " released"}, {in_ready, out_valid}, 2'b10);
      if (!exp_fl[3]) model_acc = exp_res[W-1:0];
   endtask

   initial begin
      logic [2*W-1:0] er;
      logic [3:0]     ef;
      int             el;
      logic [3:0]     rop;
      logic [W-1:0]   ra, rb;
      logic           rua;

      //            op     a      b      ua   hold res    fl       lat
      tbl[0]  = '{4'h0, 4'd9,  4'd8,  1'b0, 0, 8'h11, 4'b0110, 1};
      tbl[1]  = '{4'h1, 4'd3,  4'd5,  1'b0, 0, 8'h0E, 4'b0010, 1};
      tbl[2]  = '{4'h1, 4'd5,  4'd5,  1'b0, 0, 8'h00, 4'b0001, 1};
      tbl[3]  = '{4'h8, 4'd15, 4'd15, 1'b0, 3, 8'hE1, 4'b0000, 5};
      tbl[4]  = '{4'h9, 4'd13, 4'd4,  1'b0, 0, 8'h13, 4'b0000, 5};
      tbl[5]  = '{4'h9, 4'd7,  4'd0,  1'b0, 1, 8'h7F, 4'b1000, 1};
      tbl[6]  = '{4'h0, 4'd6,  4'd1,  1'b0, 0, 8'h07, 4'b0000, 1};
      tbl[7]  = '{4'h0, 4'd0,  4'd2,  1'b1, 0, 8'h09, 4'b0100, 1};
      tbl[8]  = '{4'h6, 4'd0,  4'd1,  1'b1, 0, 8'h02, 4'b0000, 1};
      tbl[9]  = '{4'hD, 4'd5,  4'd5,  1'b0, 0, 8'h00, 4'b1001, 1};
      tbl[10] = '{4'h0, 4'd15, 4'd0,  1'b1, 0, 8'h02, 4'b0000, 1};
      tbl[11] = '{4'h2, 4'd12, 4'd10, 1'b0, 0, 8'h08, 4'b0000, 1};
      tbl[12] = '{4'h3, 4'd12, 4'd10, 1'b0, 0, 8'h0E, 4'b0000, 1};
      tbl[13] = '{4'h4, 4'd12, 4'd10, 1'b0, 0, 8'h06, 4'b0000, 1};
      tbl[14] = '{4'h5, 4'd5,  4'd0,  1'b0, 0, 8'h0A, 4'b0000, 1};
      tbl[15] = '{4'h7, 4'd12, 4'd2,  1'b0, 0, 8'h03, 4'b0000, 1};
      tbl[16] = '{4'h6, 4'd15, 4'd5,  1'b0, 0, 8'h0E, 4'b0000, 1};
      tbl[17] = '{4'hA, 4'd3,  4'd5,  1'b0, 0, 8'h01, 4'b0000, 1};
      tbl[18] = '{4'hA, 4'd5,  4'd5,  1'b0, 0, 8'h00, 4'b0011, 1};
      tbl[19] = '{4'hB, 4'd0,  4'd9,  1'b0, 0, 8'h09, 4'b0000, 1};
      tbl[20] = '{4'h8, 4'd15, 4'd0,  1'b0, 0, 8'h00, 4'b0001, 1};
      tbl[21] = '{4'h9, 4'd3,  4'd7,  1'b0, 2, 8'h30, 4'b0000, 5};
      tbl[22] = '{4'h0, 4'd15, 4'd1,  1'b0, 0, 8'h10, 4'b0010, 1};
      tbl[23] = '{4'h1, 4'd8,  4'd1,  1'b0, 0, 8'h07, 4'b0100, 1};
      tbl[24] = '{4'hF, 4'd1,  4'd2,  1'b0, 0, 8'h00, 4'b1001, 1};

      rst = 1; in_valid = 0; op = 0; a = 0; b = 0; use_acc = 0; out_ready = 0;
      model_acc = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset state", {in_ready, out_valid, busy, result, flags}, {1'b1, 1'b0, 1'b0, 8'h00, 4'h0});
      rst = 0;

      for (int i = 0; i < 25; i++)
         do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ua,
               tbl[i].hold, tbl[i].res, tbl[i].fl, tbl[i].lat);

      // Reset in the middle of a multiply discards it and clears the accumulator.
      in_valid = 1; op = 4'h8; a = 4'd15; b = 4'd15; use_acc = 0; out_ready = 1;
      @(posedge clk); #1;
      in_valid = 0;
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0; out_ready = 0;
      check("mid-op reset", {out_valid, busy, in_ready}, 3'b001);
      model_acc = '0;
      do_op("rst acc", 4'h0, 4'd9, 4'd0, 1'b1, 0, 8'h00, 4'b0001, 1);
      do_op("rst add", 4'h0, 4'd1, 4'd1, 1'b0, 0, 8'h02, 4'b0000, 1);

      for (int n = 0; n < 200; n++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = W'($urandom);
         rb  = W'($urandom);
         rua = 1'($urandom);
         model(rop, rua ? int'(model_acc) : int'(ra), int'(rb), er, ef, el);
         do_op($sformatf("rnd%0d op%0h", n, rop), rop, ra, rb, rua,
               int'($urandom_range(0, 2)), er, ef, el);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
